alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter NOP_CODE, default 8'd255, alu_instruction value driven when no ALU operation is wanted (outside ALU codes 0..8).
REQ-002 Parameter LOOP_CODE, default 8'd16, cmd_op value selecting the decrement-until-zero loop.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present; cmd_ready  output  1  controller accepts command.
REQ-006 cmd_op  input  8  ALU code 0..8 or LOOP_CODE; cmd_data  input  32  operand for B; cmd_count  input  8  repeat/iteration limit.
REQ-007 alu_instruction  output  8  to ALU; B  output  32  operand to ALU.
REQ-008 A  input  32  ALU accumulator; z  input  1  ALU zero flag (A==0).
REQ-009 res_valid  output  1; res_ready  input  1; res_data  output  32; res_zero  output  1; res_iter  output  8; res_err  output  1.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 States: IDLE, ISSUE, LP_ISSUE, LP_CHECK, SETTLE, RESP.
REQ-012 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a posedge with cmd_valid&&cmd_ready and cmd_op/cmd_data/cmd_count are registered.
REQ-013 Accepted op 0..8 with count>0 -> ISSUE; op 0..8 with count==0 -> SETTLE (pure read of A, no ALU op); any other op (incl. LOOP_CODE when loop compiled out) -> RESP with res_err=1, no ALU op.
REQ-014 ISSUE: alu_instruction=registered op, B=registered cmd_data for exactly count consecutive cycles, then -> SETTLE.
REQ-015 Outside ISSUE/LP_ISSUE, alu_instruction SHALL be NOP_CODE and B SHALL hold its last value (0 after reset).
REQ-016 SETTLE: one cycle with NOP; at its end res_data<=A, res_zero<=z, res_iter<=cycles/iterations issued, res_err<=0; -> RESP.
REQ-017 RESP: res_valid=1 with res_* stable until the posedge where res_ready=1; then -> IDLE, res_valid=0 next cycle.
REQ-018 res_ready high in IDLE SHALL have no effect; a new command cannot be accepted in the same cycle RESP completes (IDLE cycle required).
REQ-019 LP_ISSUE (loop): if z==1 on entry or iter==count -> SETTLE without issuing; else one cycle alu_instruction=8'd2 (DEC), iter+1, -> LP_CHECK.
REQ-020 LP_CHECK: one NOP cycle so z reflects the decrement; -> LP_ISSUE.
REQ-021 Loop with count==0 issues nothing, res_iter=0.
REQ-022 res_iter SHALL be an 8-bit counter that never exceeds cmd_count (no wrap).
REQ-023 Throughput: op with count N occupies 1 (accept) + N + 1 (SETTLE) cycles before res_valid.

Reset
REQ-024 On reset: state IDLE, cmd_ready=1 next cycle, alu_instruction=NOP_CODE, B=0, res_valid=0, res_data=0, res_zero=0, res_iter=0, res_err=0, busy=0.
REQ-025 Reset in any state, including mid-ISSUE or mid-loop, SHALL abort the command with no response and stop ALU issue the following cycle.
REQ-026 Reset SHALL dominate a simultaneous cmd_valid or res_ready.

Configuration
REQ-027 Macro ALU_SEQ_CTRL_LOOP_EN: defined -> LP_ISSUE/LP_CHECK and LOOP_CODE supported per REQ-019..021.
REQ-028 Undefined -> loop states absent; LOOP_CODE treated as illegal (res_err=1, res_iter=0, no ALU op).

Verification (bench pairs block with the accumulator ALU, shared reset)
REQ-029 CLEAR count 1, then LOAD 0x10 count 1 -> res_data=0x10, res_zero=0, res_iter=1; res_valid 3 cycles after accept.
REQ-030 After REQ-029, ADD 5 count 3 -> res_data=0x1F, res_iter=3, exactly 3 cycles of alu_instruction=3, B=5.
REQ-031 LOAD 3 then LOOP_CODE count 10 (macro defined) -> res_data=0, res_zero=1, res_iter=3; count 2 instead -> res_data=1, res_iter=2.
REQ-032 cmd_op 9 -> res_err=1, alu_instruction stays NOP_CODE, A unchanged; LOOP_CODE with macro undefined -> res_err=1.
REQ-033 Reset asserted in 2nd cycle of ADD 1 count 5 -> no res_valid, alu_instruction=NOP_CODE next cycle, cmd_ready=1 after reset.
REQ-034 res_ready held low 10 cycles in RESP -> res_valid and res_* stable; cmd_ready=0 throughout.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for an accumulator ALU: accepts a command, issues the ALU op
// for cmd_count cycles (or runs a decrement-until-zero loop), then returns A. Loop support: ALU_SEQ_CTRL_LOOP_EN.
module alu_seq_ctrl #(
   parameter logic [7:0] NOP_CODE  = 8'd255,
   parameter logic [7:0] LOOP_CODE = 8'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_op,
   input  logic [31:0] cmd_data,
   input  logic [7:0]  cmd_count,
   output logic [7:0]  alu_instruction,
   output logic [31:0] B,
   input  logic [31:0] A,
   input  logic        z,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_zero,
   output logic [7:0]  res_iter,
   output logic        res_err,
   output logic        busy
);

   localparam logic [7:0] MAX_ALU_CODE = 8'd8;
`ifdef ALU_SEQ_CTRL_LOOP_EN
   localparam logic [7:0] DEC_CODE = 8'd2;
`endif

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      SETTLE,
      RESP
`ifdef ALU_SEQ_CTRL_LOOP_EN
      , LP_ISSUE
      , LP_CHECK
`endif
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  op_r;
   logic [7:0]  count_r;
   logic [7:0]  iter_r;
   logic        iter_inc;
   logic        accept;
   logic [31:0] b_r;

   assign accept    = (state == IDLE) && cmd_valid;
   assign cmd_ready = (state == IDLE);
   assign res_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign B         = b_r;

   // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_nxt       = state;
      alu_instruction = NOP_CODE;
      iter_inc        = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_op <= MAX_ALU_CODE) begin
                  state_nxt = (cmd_count == 8'd0) ? SETTLE : ISSUE;
               end else if (cmd_op == LOOP_CODE) begin
`ifdef ALU_SEQ_CTRL_LOOP_EN
                  state_nxt = LP_ISSUE;
`else
                  state_nxt = RESP;
`endif
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         ISSUE: begin
            alu_instruction = op_r;
            iter_inc        = 1'b1;
            if (iter_r + 8'd1 == count_r) state_nxt = SETTLE;
         end
`ifdef ALU_SEQ_CTRL_LOOP_EN
         LP_ISSUE: begin
            // Stop before issuing once A is zero or the iteration budget is spent.
            if (z || (iter_r == count_r)) begin
               state_nxt = SETTLE;
            end else begin
               alu_instruction = DEC_CODE;
               iter_inc        = 1'b1;
               state_nxt       = LP_CHECK;
            end
         end
         LP_CHECK: state_nxt = LP_ISSUE;
`endif
         SETTLE:  state_nxt = RESP;
         RESP:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         op_r     <= 8'd0;
         count_r  <= 8'd0;
         iter_r   <= 8'd0;
         b_r      <= 32'd0;
         res_data <= 32'd0;
         res_zero <= 1'b0;
         res_iter <= 8'd0;
         res_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_r    <= cmd_op;
            count_r <= cmd_count;
            iter_r  <= 8'd0;
            // B only moves when an op will actually be issued with it.
            if (state_nxt == ISSUE) b_r <= cmd_data;
         end else if (iter_inc) begin
            iter_r <= iter_r + 8'd1;
         end

         if (state == SETTLE) begin
            res_data <= A;
            res_zero <= z;
            res_iter <= iter_r;
            res_err  <= 1'b0;
         end else if (accept && (state_nxt == RESP)) begin
            res_data <= A;
            res_zero <= z;
            res_iter <= 8'd0;
            res_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl paired with a small accumulator ALU model sharing its reset.
module tb_alu_seq_ctrl;

   localparam logic [7:0] NOP  = 8'd255;
   localparam logic [7:0] LOOP = 8'd16;
   localparam logic [7:0] OP_CLR = 8'd0, OP_LOAD = 8'd1, OP_DEC = 8'd2, OP_ADD = 8'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_op;
   logic [31:0] cmd_data;
   logic [7:0]  cmd_count;
   logic [7:0]  alu_instruction;
   logic [31:0] B;
   logic [31:0] A;
   logic        z;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_zero;
   logic [7:0]  res_iter;
   logic        res_err;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   alu_seq_ctrl #(.NOP_CODE(NOP), .LOOP_CODE(LOOP)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
      .alu_instruction(alu_instruction), .B(B), .A(A), .z(z),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_zero(res_zero), .res_iter(res_iter), .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Accumulator ALU model: codes 0..8, anything else leaves A untouched.
   always @(posedge clk) begin
      if (reset) A <= 32'd0;
      else begin
         case (alu_instruction)
            8'd0: A <= 32'd0;
            8'd1: A <= B;
            8'd2: A <= A - 32'd1;
            8'd3: A <= A + B;
            8'd4: A <= A - B;
            8'd5: A <= A & B;
            8'd6: A <= A | B;
            8'd7: A <= A ^ B;
            8'd8: A <= A + 32'd1;
            default: A <= A;
         endcase
      end
   end
   assign z = (A == 32'd0);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one command and waits for res_valid; lat counts cycles after the accepting edge.
   task automatic run_cmd(input logic [7:0] op, input logic [31:0] data, input logic [7:0] cnt,
                          output int lat, output int n_match, output int n_issue);
      lat = 0; n_match = 0; n_issue = 0;
      @(negedge clk);
      check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      while (!res_valid && lat < 200) begin
         lat++;
         if (alu_instruction != NOP) n_issue++;
         if (alu_instruction == op && B == data) n_match++;
         @(negedge clk);
      end
      check("resp_seen", {31'd0, res_valid}, 32'd1);
   endtask

   task automatic finish_resp();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      check("resp_release", {31'd0, res_valid}, 32'd0);
      check("idle_after_resp", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      int lat, nm, ni, bad;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 8'd0; cmd_data = 32'd0;
      cmd_count = 8'd0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_alu_instr", {24'd0, alu_instruction}, {24'd0, NOP});
      check("rst_b", B, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_res_data", res_data, 32'd0);
      check("rst_res_zero", {31'd0, res_zero}, 32'd0);
      check("rst_res_iter", {24'd0, res_iter}, 32'd0);
      check("rst_res_err", {31'd0, res_err}, 32'd0);
      reset = 1'b0;

      // CLEAR then LOAD 0x10: 1 issue + settle before res_valid
      run_cmd(OP_CLR, 32'd0, 8'd1, lat, nm, ni);
      check("clr_lat", lat, 32'd2);
      finish_resp();
      run_cmd(OP_LOAD, 32'h10, 8'd1, lat, nm, ni);
      check("load_lat", lat, 32'd2);
      check("load_data", res_data, 32'h10);
      check("load_zero", {31'd0, res_zero}, 32'd0);
      check("load_iter", {24'd0, res_iter}, 32'd1);
      check("load_err", {31'd0, res_err}, 32'd0);
      // Response held for 10 cycles: everything must stay put
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!res_valid || res_data != 32'h10 || res_iter != 8'd1 || res_zero || cmd_ready || !busy)
            bad++;
      end
      check("stall_stable", bad, 32'd0);
      finish_resp();

      // ADD 5 x3: 0x10 + 15 = 0x1F
      run_cmd(OP_ADD, 32'd5, 8'd3, lat, nm, ni);
      check("add_lat", lat, 32'd4);
      check("add_match", nm, 32'd3);
      check("add_issue", ni, 32'd3);
      check("add_data", res_data, 32'h1F);
      check("add_iter", {24'd0, res_iter}, 32'd3);
      finish_resp();
      check("b_hold", B, 32'd5);

      // count 0: pure read of A, B untouched
      run_cmd(OP_ADD, 32'd7, 8'd0, lat, nm, ni);
      check("cnt0_lat", lat, 32'd1);
      check("cnt0_issue", ni, 32'd0);
      check("cnt0_data", res_data, 32'h1F);
      check("cnt0_iter", {24'd0, res_iter}, 32'd0);
      check("cnt0_b", B, 32'd5);
      finish_resp();

      // illegal op 9
      run_cmd(8'd9, 32'h99, 8'd4, lat, nm, ni);
      check("ill_lat", lat, 32'd0);
      check("ill_issue", ni, 32'd0);
      check("ill_err", {31'd0, res_err}, 32'd1);
      check("ill_iter", {24'd0, res_iter}, 32'd0);
      check("ill_a", A, 32'h1F);
      finish_resp();

`ifdef ALU_SEQ_CTRL_LOOP_EN
      // LOAD 3, loop 10: DEC three times, stops on zero
      run_cmd(OP_LOAD, 32'd3, 8'd1, lat, nm, ni);
      finish_resp();
      run_cmd(LOOP, 32'd0, 8'd10, lat, nm, ni);
      check("loop10_data", res_data, 32'd0);
      check("loop10_zero", {31'd0, res_zero}, 32'd1);
      check("loop10_iter", {24'd0, res_iter}, 32'd3);
      check("loop10_decs", ni, 32'd3);
      check("loop10_err", {31'd0, res_err}, 32'd0);
      finish_resp();
      // LOAD 3, loop 2: budget runs out at A=1
      run_cmd(OP_LOAD, 32'd3, 8'd1, lat, nm, ni);
      finish_resp();
      run_cmd(LOOP, 32'd0, 8'd2, lat, nm, ni);
      check("loop2_data", res_data, 32'd1);
      check("loop2_zero", {31'd0, res_zero}, 32'd0);
      check("loop2_iter", {24'd0, res_iter}, 32'd2);
      check("loop2_decs", ni, 32'd2);
      finish_resp();
      run_cmd(LOOP, 32'd0, 8'd0, lat, nm, ni);
      check("loop0_iter", {24'd0, res_iter}, 32'd0);
      check("loop0_decs", ni, 32'd0);
      check("loop0_data", res_data, 32'd1);
      finish_resp();
`else
      run_cmd(LOOP, 32'd0, 8'd10, lat, nm, ni);
      check("noloop_err", {31'd0, res_err}, 32'd1);
      check("noloop_iter", {24'd0, res_iter}, 32'd0);
      check("noloop_issue", ni, 32'd0);
      check("noloop_a", A, 32'h1F);
      finish_resp();
      check("noloop_op_dec_unused", {24'd0, OP_DEC}, {24'd0, alu_instruction} - 32'd253);
`endif

      // res_ready in IDLE does nothing
      @(negedge clk);
      res_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_rdy_valid", {31'd0, res_valid}, 32'd0);
      check("idle_rdy_busy", {31'd0, busy}, 32'd0);
      res_ready = 1'b0;

      // Reset in the 2nd ISSUE cycle of ADD 1 x5, with cmd_valid and res_ready also high
      @(negedge clk);
      cmd_op = OP_ADD; cmd_data = 32'd1; cmd_count = 8'd5; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("abort_issue1", {24'd0, alu_instruction}, {24'd0, OP_ADD});
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1; cmd_valid = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      check("abort_nop", {24'd0, alu_instruction}, {24'd0, NOP});
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_b", B, 32'd0);
      reset = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
      @(negedge clk);
      check("abort_ready", {31'd0, cmd_ready}, 32'd1);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (res_valid || busy || alu_instruction != NOP) bad++;
      end
      check("abort_quiet", bad, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
